// File: rtl/yuv_pkg.sv
// Shared definitions for the YUV422 -> USB3 packing path.
// Holds word/beat widths, the serialiser state type and a lane byte-swap helper.
// Related build macro: YUV_PACKER_BYTE_SWAP_EN (selects the byte swap in yuv_usb_packer).
package yuv_pkg;

    localparam int unsigned YUV_WORD_W     = 128;
    localparam int unsigned USB_BEAT_W     = 32;
    localparam int unsigned BEATS_PER_WORD = YUV_WORD_W / USB_BEAT_W;
    localparam int unsigned BEAT_CNT_W     = $clog2(BEATS_PER_WORD);

    typedef enum logic {
        ST_EMPTY,
        ST_SEND
    } packer_state_e;

    // Swap the two bytes of every 16-bit pixel lane: {hi,lo} -> {lo,hi}.
    function automatic logic [YUV_WORD_W-1:0] byte_swap_lanes(input logic [YUV_WORD_W-1:0] w);
        logic [YUV_WORD_W-1:0] r;
        r = '0;
        for (int k = 0; k < YUV_WORD_W / 16; k++) begin
            r[16*k +: 16] = {w[16*k +: 8], w[16*k + 8 +: 8]};
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_128.sv
// Synchronous single-clock FIFO of 128-bit words with a registered level.
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   push, wdata     : write request and data (ignored when full unless popping too)
//   pop             : read request, advances the head (ignored when empty)
//   rdata           : current head word (valid while level > 0)
//   level           : number of stored entries
module sync_fifo_128
    import yuv_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [YUV_WORD_W-1:0] wdata,
    input  logic                  pop,
    output logic [YUV_WORD_W-1:0] rdata,
    output logic [LW-1:0]         level
);

    logic [YUV_WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  do_push, do_pop;

    assign do_pop  = pop && (level_q != '0);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_push = push && ((level_q != LW'(DEPTH)) || do_pop);

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/yuv_usb_packer.sv
// Buffers 128-bit YUV422 words and serialises each into four 32-bit beats
// (lowest 32 bits first) on a valid/ready interface. Upstream has no ready, so
// words arriving while the FIFO is full are dropped and flagged.
// Build macro: YUV_PACKER_BYTE_SWAP_EN byte-swaps every 16-bit lane on FIFO write.
// Ports:
//   clk_i, reset_n_i    : clock, synchronous active-low reset
//   yuv_i, yuv_valid_i  : input word and its valid strobe
//   out_ready_i         : downstream accepts data_o
//   data_o, data_valid_o: output beat and its valid
//   fifo_level_o        : buffered words (excludes the word being serialised)
//   overflow_o          : sticky drop flag, cleared by overflow_clr_i (set wins)
module yuv_usb_packer
    import yuv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [YUV_WORD_W-1:0] yuv_i,
    input  logic                  yuv_valid_i,
    input  logic                  out_ready_i,
    output logic [USB_BEAT_W-1:0] data_o,
    output logic                  data_valid_o,
    output logic [LW-1:0]         fifo_level_o,
    output logic                  overflow_o,
    input  logic                  overflow_clr_i
);

    packer_state_e         state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [YUV_WORD_W-1:0] shreg_q, shreg_d;
    logic                  overflow_q, overflow_d;
    logic                  pop, drop;
    logic [YUV_WORD_W-1:0] wr_word, head_word;
    logic [LW-1:0]         level;

`ifdef YUV_PACKER_BYTE_SWAP_EN
    assign wr_word = byte_swap_lanes(yuv_i);
`else
    assign wr_word = yuv_i;
`endif

    sync_fifo_128 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .push    (yuv_valid_i),
        .wdata   (wr_word),
        .pop     (pop),
        .rdata   (head_word),
        .level   (level)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        shreg_d      = shreg_q;
        pop          = 1'b0;
        data_valid_o = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    shreg_d = head_word;
                    beat_d  = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                data_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (beat_q != BEAT_CNT_W'(BEATS_PER_WORD - 1)) begin
                        beat_d  = beat_q + BEAT_CNT_W'(1);
                        shreg_d = shreg_q >> USB_BEAT_W;
                    end else if (level != '0) begin
                        // Back-to-back load keeps the beat stream bubble-free.
                        pop     = 1'b1;
                        shreg_d = head_word;
                        beat_d  = '0;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Must mirror the FIFO's own accept rule so the flag matches actual drops.
    assign drop = yuv_valid_i && (level == LW'(FIFO_DEPTH)) && !pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_EMPTY;
            beat_q     <= '0;
            shreg_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            shreg_q    <= shreg_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_o       = shreg_q[USB_BEAT_W-1:0];
    assign fifo_level_o = level;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_yuv_usb_packer.sv
// Directed bench for yuv_usb_packer (FIFO_DEPTH = 8): single word, back-pressure,
// overflow and clear, full push/pop, mid-word reset.
module tb_yuv_usb_packer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] yuv;
    logic         yuv_valid;
    logic         out_ready;
    logic [31:0]  data;
    logic         data_valid;
    logic [3:0]   fifo_level;
    logic         overflow;
    logic         overflow_clr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    yuv_usb_packer #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .yuv_i          (yuv),
        .yuv_valid_i    (yuv_valid),
        .out_ready_i    (out_ready),
        .data_o         (data),
        .data_valid_o   (data_valid),
        .fifo_level_o   (fifo_level),
        .overflow_o     (overflow),
        .overflow_clr_i (overflow_clr)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected beat as seen on data_o for an unswapped 32-bit slice.
    function automatic logic [31:0] exp_beat(input logic [31:0] x);
`ifdef YUV_PACKER_BYTE_SWAP_EN
        return {x[23:16], x[31:24], x[7:0], x[15:8]};
`else
        return x;
`endif
    endfunction

    // Word tagged with id: beat j = {id, j}.
    function automatic logic [127:0] mk_word(input int id);
        logic [127:0] w;
        for (int j = 0; j < 4; j++) w[32*j +: 32] = {id[15:0], 16'(j)};
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bp_beats [4];
    int idx, n, wi, jb, id;

    initial begin
        bp_beats = '{32'h11110001, 32'h22220002, 32'h33330003, 32'h44440004};
        reset_n = 1'b0; yuv = '0; yuv_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
        step(); step();
        check("rst_data", data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        step();

        // Single word, ready high.
        yuv = 128'h000F000E_000D000C_000B000A_00090008; yuv_valid = 1'b1; out_ready = 1'b1;
        step();
        yuv_valid = 1'b0;
        check("sw_level_after_write", fifo_level, 1);
        check("sw_valid_after_write", data_valid, 0);
        step();
        check("sw_valid0", data_valid, 1);
        check("sw_beat0", data, exp_beat(32'h00090008));
        check("sw_level_after_pop", fifo_level, 0);
        step();
        check("sw_beat1", data, exp_beat(32'h000B000A));
        step();
        check("sw_beat2", data, exp_beat(32'h000D000C));
        step();
        check("sw_beat3", data, exp_beat(32'h000F000E));
        step();
        check("sw_valid_end", data_valid, 0);

        // Back-pressure: ready pattern 1,0,0,1 repeating.
        out_ready = 1'b0;
        yuv = 128'h44440004_33330003_22220002_11110001; yuv_valid = 1'b1;
        step();
        yuv_valid = 1'b0;
        step();
        idx = 0;
        for (int i = 0; i < 16 && idx < 4; i++) begin
            check("bp_valid", data_valid, 1);
            check("bp_beat", data, exp_beat(bp_beats[idx]));
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
            if (out_ready) idx++;
        end
        check("bp_count", idx, 4);
        check("bp_valid_end", data_valid, 0);

        // Overflow: 10 words with ready low; id 10 is dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            yuv = mk_word(k + 1); yuv_valid = 1'b1;
            step();
        end
        yuv_valid = 1'b0;
        check("ovf_level", fifo_level, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_valid", data_valid, 1);
        check("ovf_head_beat", data, exp_beat(32'h00010000));

        // Clear coinciding with a drop: set wins.
        yuv = mk_word(99); yuv_valid = 1'b1; overflow_clr = 1'b1;
        step();
        yuv_valid = 1'b0;
        check("clr_set_wins", overflow, 1);
        check("clr_level", fifo_level, 8);
        step();
        overflow_clr = 1'b0;
        check("clr_alone", overflow, 0);

        // Drain; push id 11 as the loaded word's last beat leaves (FIFO full).
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (data_valid !== 1'b1) break;
            wi = n / 4; jb = n % 4;
            id = (wi < 9) ? wi + 1 : 11;
            check("drain_beat", data, exp_beat({id[15:0], jb[15:0]}));
            if (n == 3) begin
                yuv = mk_word(11); yuv_valid = 1'b1;
            end
            step();
            yuv_valid = 1'b0;
            if (n == 3) begin
                check("full_pushpop_level", fifo_level, 8);
                check("full_pushpop_ovf", overflow, 0);
            end
            n++;
        end
        check("drain_count", n, 40);
        check("drain_valid_end", data_valid, 0);

        // Mid-word reset with three words queued.
        for (int k = 0; k < 4; k++) begin
            yuv = mk_word(20 + k); yuv_valid = 1'b1;
            step();
        end
        yuv_valid = 1'b0;
        check("mr_beat2", data, exp_beat(32'h00140002));
        check("mr_level", fifo_level, 3);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mr_valid", data_valid, 0);
        check("mr_level_clr", fifo_level, 0);
        check("mr_data", data, 0);
        step(); step();
        check("mr_valid_idle", data_valid, 0);
        check("mr_level_idle", fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/yuv_usb_packer.md
# yuv_usb_packer

Downstream neighbour of `rgb_to_yuv`. Accepts 128-bit YUV422 words (8 pixels × 16 bit) on a valid-only interface and buffers them in a small FIFO. Serialises each word into four 32-bit beats with a valid/ready handshake toward the USB3 slave-FIFO writer. Input drops caused by back-pressure are flagged rather than stalling the converter, which has no ready input.

## Interface
- `FIFO_DEPTH`, default 8: number of 128-bit entries. Must be a power of two, ≥ 2.
- `clk_i`, input, 1: single clock. All logic is on the rising edge.
- `reset_n_i`, input, 1: reset, synchronous and active-low.
- `yuv_i`, input, 128: YUV422 word, lane k = `yuv_i[16k+15:16k]`.
- `yuv_valid_i`, input, 1: `yuv_i` is valid this cycle. There is no ready path back upstream.
- `out_ready_i`, input, 1: downstream accepts `data_o` this cycle.
- `data_o`, output, 32: output beat.
- `data_valid_o`, output, 1: `data_o` holds a valid beat.
- `fifo_level_o`, output, $clog2(FIFO_DEPTH)+1: entries currently stored. Does not count the word being serialised.
- `overflow_o`, output, 1: sticky flag, set when an input word was dropped.
- `overflow_clr_i`, input, 1: clears `overflow_o`.

## Operation
- **FIFO write**
  - When `yuv_valid_i`=1, the word is written if level < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the word is discarded and `overflow_o` is set.
  - If set and clear coincide, set wins.
- **Serialiser FSM states**
  - EMPTY: `data_valid_o`=0. If FIFO level > 0, pop the head into the shift register, set beat=0, go to SEND.
  - SEND: `data_valid_o`=1. Beat k outputs `word[32k+31:32k]`, lowest 32 bits first.
    - On `out_ready_i`=1 with beat<3: increment beat.
    - On `out_ready_i`=1 with beat==3: if the FIFO is non-empty, pop and load the next word with beat=0 in the same cycle and stay in SEND. Otherwise go to EMPTY.
- `data_o` and `data_valid_o` hold stable while `out_ready_i`=0.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The level counter is updated by +1 (write only), −1 (pop only), or unchanged (both or neither).
- Reset clears pointers, level, FSM (EMPTY), beat counter and `overflow_o`. Reset mid-word discards the partially sent word and all buffered words. No beat is emitted in the cycle after reset.

## Timing
- Reset values: `data_o`=0, `data_valid_o`=0, `fifo_level_o`=0, `overflow_o`=0.
- Latency:
  - Word written at edge N into an empty FIFO with the FSM in EMPTY.
  - Popped at edge N+1.
  - Beat 0 is visible after edge N+1 with `data_valid_o`=1.
- Throughput is 4 beats per word with no bubbles between words while `out_ready_i` stays high.
- Sustained input rate must not exceed one word per 4 cycles. Faster input fills the FIFO and then drops words.
- `fifo_level_o` and `overflow_o` are registered and reflect state after the edge.

## Configuration
- `YUV_PACKER_BYTE_SWAP_EN` defined: each 16-bit lane is byte-swapped on FIFO write, so `{hi,lo}` becomes `{lo,hi}`. The output is big-endian per pixel, matching the host viewer format.
- Not defined: data passes unmodified.

## Structure
- Shared package `yuv_pkg` holds:
  - `YUV_WORD_W`=128.
  - `USB_BEAT_W`=32.
  - `BEATS_PER_WORD`=4.
  - The FSM state enum {`ST_EMPTY`, `ST_SEND`}.
- One sub-module, `sync_fifo_128`. It is a synchronous single-clock FIFO with registered level and simultaneous push/pop when full. The packer instantiates it and contains only the FSM, the shift register and the overflow logic.

## Test plan
- **Single word:** after reset, `yuv_i`=128'h000F000E_000D000C_000B000A_00090008, `out_ready_i`=1.
  - Without the macro: beats 0x00090008, 0x000B000A, 0x000D000C, 0x000F000E on consecutive cycles, first beat one edge after the write.
  - With the macro: first beat is 0x09000800.
- **Back-pressure:** `out_ready_i` toggles 1,0,0,1,… The beat value is stable while ready is low. All 4 beats arrive in order, and `data_valid_o` falls after the 4th.
- **Overflow:** `FIFO_DEPTH`=8, `out_ready_i`=0, 10 consecutive valid words.
  - `fifo_level_o`=8, `overflow_o`=1.
  - After releasing ready, exactly 1+8 words (36 beats) emerge: the loaded word plus the 8 buffered words, with the 10th word dropped.
- **Full with simultaneous push/pop:** FIFO full, final beat accepted in the same cycle as a new valid word. The word is accepted, level stays 8, and `overflow_o` stays 0.
- **Mid-operation reset:** `reset_n_i`=0 for one cycle during beat 2 with 3 words queued. Next cycle: `data_valid_o`=0, `fifo_level_o`=0, and no further beats until new input.
- **Overflow clear:** `overflow_clr_i` and a drop in the same cycle leave `overflow_o`=1. `overflow_clr_i` alone clears it to 0.
